uart_rx_fsm: RTL and testbench

- UART receiver controller. It is the receive-side counterpart of the UART TX path.
- Oversamples the serial line at prescale × bit rate and recovers each frame: start bit, 8 data bits LSB first, optional parity bit, stop bit.
- Checks parity and stop bit, then presents the byte with a one-cycle valid strobe to the RX-side clock-domain logic.
- Runs entirely in the UART RX clock domain; rx_in is asynchronous and is synchronised inside the block.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_sampler.sv | 66 ++++++
 rtl/uart_rx_fsm.sv | 116 +++++++++++
 tb/tb_uart_rx_fsm.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity selectors and
// the legal oversampling ratios, used by both RX and TX controllers.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Anything that is not 16 or 32 falls back to 8x oversampling.
    function automatic int eff_prescale(input int p);
        if (p == PRESCALE_16) return PRESCALE_16;
        if (p == PRESCALE_32) return PRESCALE_32;
        return PRESCALE_8;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line front end: 2-flop synchroniser, per-bit edge counter and a
// 3-sample majority vote around the bit centre.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      rx_s,
    output logic                      edge_last,
    output logic                      sample_valid,
    output logic                      sampled_bit
);

    logic                      rx_m;
    logic                      s0;
    logic                      s1;
    logic [PRESCALE_WIDTH-1:0] edge_cnt;
    logic [PRESCALE_WIDTH-1:0] p_eff;
    logic [PRESCALE_WIDTH-1:0] half;

    always_comb begin
        p_eff = PRESCALE_WIDTH'(eff_prescale(int'(prescale)));
        half  = p_eff >> 1;
    end

    // >= rather than == so a mid-frame prescale drop still wraps.
    assign edge_last = (edge_cnt >= p_eff - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            edge_cnt     <= '0;
            s0           <= 1'b0;
            s1           <= 1'b0;
            sampled_bit  <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (!en || edge_last) edge_cnt <= '0;
            else                  edge_cnt <= edge_cnt + 1'b1;
            if (en) begin
                if (edge_cnt == half - 1'b1) s0 <= rx_s;
                if (edge_cnt == half)        s1 <= rx_s;
                if (edge_cnt == half + 1'b1) begin
                    sampled_bit  <= (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
                    sample_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: frame FSM, deserializer, parity and stop
// checking, with one-cycle result strobes at end of frame.
module uart_rx_fsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      par_en,
    input  logic                      par_typ,
    output logic [DATA_WIDTH-1:0]     p_data,
    output logic                      data_valid,
    output logic                      par_err,
    output logic                      stp_err
);

    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    uart_state_e           state;
    uart_state_e           state_nxt;
    logic                  rx_s;
    logic                  edge_last;
    logic                  sample_valid;
    logic                  sampled_bit;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  par_bad;
    logic                  stop_bit;
    logic                  exp_par;
    logic                  frame_go;

    uart_rx_sampler #(
        .PRESCALE_WIDTH(PRESCALE_WIDTH)
    ) u_sampler (
        .clk         (clk),
        .reset       (reset),
        .en          (state != IDLE),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .rx_s        (rx_s),
        .edge_last   (edge_last),
        .sample_valid(sample_valid),
        .sampled_bit (sampled_bit)
    );

    assign frame_go = (state == IDLE) && !rx_s;
    assign exp_par  = (par_typ_q == PAR_EVEN) ? ^shreg : ~^shreg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (edge_last) state_nxt = sampled_bit ? IDLE : DATA;
            DATA:
                if (edge_last && bit_cnt == LAST_BIT)
                    state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (edge_last) state_nxt = STOP;
            STOP:    if (edge_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            par_bad    <= 1'b0;
            stop_bit   <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            if (frame_go) begin
                par_en_q  <= par_en;
                par_typ_q <= par_typ;
                par_bad   <= 1'b0;
                bit_cnt   <= '0;
            end
            if (state == DATA && sample_valid)
                shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
            if (state == DATA && edge_last)
                bit_cnt <= bit_cnt + 1'b1;
            if (state == PARITY && sample_valid)
                par_bad <= (sampled_bit != exp_par);
            if (state == STOP && sample_valid)
                stop_bit <= sampled_bit;
            if (state == STOP && edge_last) begin
                par_err <= par_bad;
                stp_err <= !stop_bit;
                if (stop_bit && !par_bad) begin
                    p_data     <= shreg;
                    data_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed frames plus randomized
// frames checked against a frame-level reference model.
module tb_uart_rx_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    int unsigned start_cyc;
    logic [7:0] exp_pdata;

    typedef struct {
        logic        v;
        logic        pe;
        logic        se;
        logic [7:0]  d;
        int unsigned c;
    } ev_t;

    ev_t evq[$];

    uart_rx_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .rx_in     (rx_in),
        .prescale  (prescale),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe cycle becomes one event; a wide strobe shows as two.
    always @(negedge clk)
        if (reset && (data_valid || par_err || stp_err))
            evq.push_back('{data_valid, par_err, stp_err, p_data, cyc});

    function automatic int bit_len(input logic [5:0] ps);
        if (ps == 6'd16) return 16;
        if (ps == 6'd32) return 32;
        return 8;
    endfunction

    // Frame outcome {valid, parity error, stop error} from the bits sent.
    function automatic logic [2:0] model(input logic [7:0] d,
                                         input logic pen, input logic ptyp,
                                         input logic pbit, input logic stop);
        int   ones;
        logic pe;
        logic se;
        ones = $countones(d) + ((pen && pbit) ? 1 : 0);
        pe   = pen && ((ones % 2) != (ptyp ? 1 : 0));
        se   = !stop;
        return {!pe && !se, pe, se};
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [5:0] ps, input logic [7:0] d,
                              input logic pen, input logic ptyp,
                              input logic pbit, input logic stop,
                              input int gap);
        int p;
        p        = bit_len(ps);
        prescale = ps;
        par_en   = pen;
        par_typ  = ptyp;
        rx_in    = 1'b0;
        start_cyc = cyc;
        settle(p);
        par_en  = 1'($urandom);
        par_typ = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            settle(p);
        end
        if (pen) begin
            rx_in = pbit;
            settle(p);
        end
        rx_in = stop;
        settle(p);
        rx_in = 1'b1;
        settle(gap);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        rx_in = 1'b1;
        prescale = 6'd8;
        par_en = 1'b0;
        par_typ = 1'b0;
        settle(4);
        checks++;
        if ({p_data, data_valid, par_err, stp_err} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {p_data, data_valid, par_err, stp_err});
        end
        reset = 1'b1;
        exp_pdata = 8'h00;
        settle(4);
        evq.delete();
    endtask

    task automatic test_basic_p8();
        ev_t e;
        send_frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL basic_count got=%0d exp=1", evq.size());
        end else begin
            e = evq.pop_front();
            checks++;
            if ({e.v, e.pe, e.se, e.d} !== {3'b100, 8'hA5}) begin
                failures++;
                $display("FAIL basic_event got=%b%b%b/%h exp=100/a5",
                         e.v, e.pe, e.se, e.d);
            end
            checks++;
            if (e.c - start_cyc < 82 || e.c - start_cyc > 84) begin
                failures++;
                $display("FAIL basic_latency got=%0d exp=82..84",
                         e.c - start_cyc);
            end
        end
        exp_pdata = 8'hA5;
        checks++;
        if (p_data !== exp_pdata) begin
            failures++;
            $display("FAIL basic_hold got=%h exp=%h", p_data, exp_pdata);
        end
        evq.delete();
    endtask

    task automatic test_parity_p16();
        ev_t e;
        send_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 20);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL par_good_count got=%0d exp=1", evq.size());
        end else begin
            e = evq.pop_front();
            checks++;
            if ({e.v, e.pe, e.se, e.d} !== {3'b100, 8'h3C}) begin
                failures++;
                $display("FAIL par_good got=%b%b%b/%h exp=100/3c",
                         e.v, e.pe, e.se, e.d);
            end
        end
        exp_pdata = 8'h3C;
        evq.delete();
        send_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 20);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL par_bad_count got=%0d exp=1", evq.size());
        end else begin
            e = evq.pop_front();
            checks++;
            if ({e.v, e.pe, e.se} !== 3'b010) begin
                failures++;
                $display("FAIL par_bad got=%b%b%b exp=010", e.v, e.pe, e.se);
            end
        end
        checks++;
        if (p_data !== exp_pdata) begin
            failures++;
            $display("FAIL par_bad_hold got=%h exp=%h", p_data, exp_pdata);
        end
        evq.delete();
    endtask

    task automatic test_stop_err_p32();
        ev_t e;
        send_frame(6'd32, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 40);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL stop_count got=%0d exp=1", evq.size());
        end else begin
            e = evq.pop_front();
            checks++;
            if ({e.v, e.pe, e.se} !== 3'b001) begin
                failures++;
                $display("FAIL stop_err got=%b%b%b exp=001", e.v, e.pe, e.se);
            end
        end
        checks++;
        if (p_data !== exp_pdata) begin
            failures++;
            $display("FAIL stop_hold got=%h exp=%h", p_data, exp_pdata);
        end
        evq.delete();
    endtask

    task automatic test_glitch();
        prescale = 6'd16;
        rx_in = 1'b0;
        settle(3);
        rx_in = 1'b1;
        settle(40);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL glitch_strobes got=%0d exp=0", evq.size());
        end
        evq.delete();
    endtask

    task automatic test_back_to_back();
        ev_t e;
        send_frame(6'd8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 0);
        send_frame(6'd8, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=2", evq.size());
        end else begin
            e = evq.pop_front();
            checks++;
            if ({e.v, e.pe, e.se, e.d} !== {3'b100, 8'h55}) begin
                failures++;
                $display("FAIL b2b_first got=%b%b%b/%h exp=100/55",
                         e.v, e.pe, e.se, e.d);
            end
            e = evq.pop_front();
            checks++;
            if ({e.v, e.pe, e.se, e.d} !== {3'b100, 8'hFF}) begin
                failures++;
                $display("FAIL b2b_second got=%b%b%b/%h exp=100/ff",
                         e.v, e.pe, e.se, e.d);
            end
        end
        exp_pdata = 8'hFF;
        evq.delete();
    endtask

    task automatic test_reset_mid_frame();
        ev_t e;
        logic [7:0] d;
        int bad;
        d = 8'h81;
        prescale = 6'd8;
        par_en = 1'b0;
        rx_in = 1'b0;
        settle(8);
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            settle(8);
        end
        rx_in = d[4];
        settle(4);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            settle(1);
            if ({p_data, data_valid, par_err, stp_err} !== 11'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL mid_reset_outputs got=%0d nonzero cycles exp=0",
                     bad);
        end
        rx_in = 1'b1;
        reset = 1'b1;
        exp_pdata = 8'h00;
        settle(100);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_strobes got=%0d exp=0", evq.size());
        end
        evq.delete();
        send_frame(6'd8, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 16);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL after_reset_count got=%0d exp=1", evq.size());
        end else begin
            e = evq.pop_front();
            checks++;
            if ({e.v, e.d} !== {1'b1, 8'h7E}) begin
                failures++;
                $display("FAIL after_reset got=%b/%h exp=1/7e", e.v, e.d);
            end
        end
        exp_pdata = 8'h7E;
        evq.delete();
    endtask

    task automatic test_break();
        int nse;
        int nother;
        prescale = 6'd8;
        par_en = 1'b0;
        rx_in = 1'b0;
        settle(161);
        rx_in = 1'b1;
        settle(24);
        nse = 0;
        nother = 0;
        foreach (evq[i]) begin
            if (evq[i].se && !evq[i].v && !evq[i].pe) nse++;
            else nother++;
        end
        checks++;
        if (nse != 2 || nother != 0) begin
            failures++;
            $display("FAIL break_strobes got=%0d stp/%0d other exp=2/0",
                     nse, nother);
        end
        checks++;
        if (p_data !== exp_pdata) begin
            failures++;
            $display("FAIL break_hold got=%h exp=%h", p_data, exp_pdata);
        end
        evq.delete();
    endtask

    task automatic test_random();
        ev_t e;
        logic [5:0] ps;
        logic [7:0] d;
        logic pen, ptyp, pbit, stop;
        logic [2:0] exp;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 3))
                0:       ps = 6'd8;
                1:       ps = 6'd16;
                2:       ps = 6'd32;
                default: ps = 6'($urandom_range(0, 63));
            endcase
            d    = 8'($urandom);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            exp  = model(d, pen, ptyp, pbit, stop);
            send_frame(ps, d, pen, ptyp, pbit, stop, 10);
            if (exp[2]) exp_pdata = d;
            checks++;
            if (evq.size() != 1) begin
                failures++;
                $display("FAIL rand%0d_count got=%0d exp=1", n, evq.size());
            end else begin
                e = evq.pop_front();
                checks++;
                if ({e.v, e.pe, e.se, e.d} !== {exp, exp_pdata}) begin
                    failures++;
                    $display("FAIL rand%0d got=%b%b%b/%h exp=%b/%h",
                             n, e.v, e.pe, e.se, e.d, exp, exp_pdata);
                end
            end
            evq.delete();
        end
    endtask

    initial begin
        test_reset();
        test_basic_p8();
        test_parity_p16();
        test_stop_err_p32();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_break();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
